// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: F-stage PC register and branch/jump redirect with delay-slot handling.
module branch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        d_valid,
   input  logic        d_is_branch,
   input  logic        d_is_likely,
   input  logic        d_is_jump,
   input  logic        d_is_jr,
   input  logic        to_branch,
   input  logic [31:0] d_pc,
   input  logic [15:0] d_imm16,
   input  logic [25:0] d_index26,
   input  logic [31:0] d_rs_value,
   output logic [31:0] pc_f,
   output logic [31:0] npc,
   output logic        nullify_fd,
   output logic [31:0] link_pc,
   output logic        redirect_pending
);
   typedef enum logic {SEQ, WAIT_DS} state_t;
   state_t      state, state_nx;
   logic [31:0] pend_target, pend_target_nx, seq_pc, d_pc4, target;
   logic        pend_redir, pend_redir_nx, pend_null, pend_null_nx;
   logic        adv, accept, take, kill, hit;
   assign adv     = imem_ready && !stall;
   assign accept  = d_valid && !stall;
   assign take    = d_is_jr || d_is_jump || (d_is_branch && to_branch);
   assign kill    = d_is_branch && d_is_likely && !to_branch;
   assign seq_pc  = pc_f + PC_STEP;
   assign d_pc4   = d_pc + 32'd4;
   assign link_pc = d_pc + 32'd8;
   assign target  = d_is_jr   ? d_rs_value :
                    d_is_jump ? {d_pc4[31:28], d_index26, 2'b00} :
                                d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
   assign hit     = state == SEQ && accept && (take || kill);
   assign redirect_pending = state == WAIT_DS;
   always_comb begin
      state_nx       = state;
      pend_target_nx = pend_target;
      pend_redir_nx  = pend_redir;
      pend_null_nx   = pend_null;
      npc            = adv ? seq_pc : pc_f;
      nullify_fd     = 1'b0;
      if (state == WAIT_DS) begin
         if (adv) begin
            npc           = pend_redir ? pend_target : seq_pc;
            nullify_fd    = pend_null;
            pend_redir_nx = 1'b0;
            pend_null_nx  = 1'b0;
            state_nx      = SEQ;
         end
      end else if (hit) begin
         if (adv) begin
            npc        = take ? target : seq_pc;
            nullify_fd = kill;
         end else begin
            // delay slot not fetched yet: park the redirect until it is
            pend_target_nx = target;
            pend_redir_nx  = take;
            pend_null_nx   = kill;
            state_nx       = WAIT_DS;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f        <= RESET_PC;
         state       <= SEQ;
         pend_target <= '0;
         pend_redir  <= 1'b0;
         pend_null   <= 1'b0;
      end else begin
         pc_f        <= npc;
         state       <= state_nx;
         pend_target <= pend_target_nx;
         pend_redir  <= pend_redir_nx;
         pend_null   <= pend_null_nx;
      end
   end
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: vector table, directed sequences and randomized model check.
module tb_branch_redirect_unit;
   logic clk = 0, reset, stall, imem_ready, d_valid, d_is_branch, d_is_likely, d_is_jump, d_is_jr, to_branch;
   logic [31:0] d_pc, d_rs_value, pc_f, npc, link_pc;
   logic [15:0] d_imm16;
   logic [25:0] d_index26;
   logic nullify_fd, redirect_pending;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   branch_redirect_unit dut (.clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
      .d_valid(d_valid), .d_is_branch(d_is_branch), .d_is_likely(d_is_likely), .d_is_jump(d_is_jump),
      .d_is_jr(d_is_jr), .to_branch(to_branch), .d_pc(d_pc), .d_imm16(d_imm16), .d_index26(d_index26),
      .d_rs_value(d_rs_value), .pc_f(pc_f), .npc(npc), .nullify_fd(nullify_fd), .link_pc(link_pc),
      .redirect_pending(redirect_pending));
   typedef struct packed {
      logic rst, stl, rdy, vld, br, lk, jmp, jr, tkn;
      logic [31:0] dpc;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] rs;
   } in_t;
   typedef struct {
      in_t i;
      logic [31:0] e_npc;
      logic e_null, e_pend;
   } vec_t;
   typedef struct {
      logic [31:0] tgt;
      bit redir, nul;
   } pend_t;
   function automatic in_t ev(logic stl, rdy, vld, br, lk, jmp, jr, tkn, logic [31:0] dpc,
                              logic [15:0] imm, logic [25:0] idx, logic [31:0] rs);
      return '{1'b0, stl, rdy, vld, br, lk, jmp, jr, tkn, dpc, imm, idx, rs};
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(in_t v);
      @(negedge clk);
      {reset, stall, imem_ready, d_valid, d_is_branch, d_is_likely, d_is_jump, d_is_jr, to_branch}
         = {v.rst, v.stl, v.rdy, v.vld, v.br, v.lk, v.jmp, v.jr, v.tkn};
      d_pc = v.dpc; d_imm16 = v.imm; d_index26 = v.idx; d_rs_value = v.rs;
      #1;
   endtask
   in_t idle, rst_v;
   task automatic do_reset();
      drive(rst_v);
      @(posedge clk);
   endtask
   // reference model: PC plus a queue of parked redirects (non-empty == waiting for delay slot)
   logic [31:0] m_pc;
   pend_t pq[$];
   task automatic model_step(in_t v);
      bit adv, acc, take, kill;
      logic [31:0] tgt, e_npc, pc4;
      logic e_null;
      adv = v.rdy && !v.stl; acc = v.vld && !v.stl;
      take = v.jr || v.jmp || (v.br && v.tkn);
      kill = v.br && v.lk && !v.tkn;
      pc4 = v.dpc + 4;
      tgt = v.jr ? v.rs : v.jmp ? ((pc4 & 32'hF000_0000) | (32'(v.idx) * 4))
                             : pc4 + 32'($signed(v.imm) * 4);
      e_null = 0;
      e_npc = adv ? m_pc + 4 : m_pc;
      if (pq.size() != 0) begin
         if (adv) begin
            e_npc = pq[0].redir ? pq[0].tgt : m_pc + 4;
            e_null = pq[0].nul;
         end
      end else if (acc && (take || kill)) begin
         if (adv) begin
            e_npc = take ? tgt : m_pc + 4;
            e_null = kill;
         end
      end
      chk("rnd_npc", npc, e_npc);
      chk("rnd_null", nullify_fd, e_null);
      chk("rnd_pend", redirect_pending, pq.size() != 0);
      chk("rnd_link", link_pc, v.dpc + 8);
      chk("rnd_pcf", pc_f, m_pc);
      if (pq.size() != 0) begin
         if (adv) void'(pq.pop_front());
      end else if (acc && (take || kill) && !adv) pq.push_back('{tgt, take, kill});
      m_pc = e_npc;
      if (v.rst) begin
         m_pc = 32'h3000;
         pq.delete();
      end
   endtask
   vec_t tbl[15];
   in_t r;
   initial begin
      idle  = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_v = idle; rst_v.rst = 1;
      tbl[0]  = '{ev(0,1,0,0,0,0,0,0, 32'h3004, 16'h0003, 0, 0), 32'h3004, 0, 0};
      tbl[1]  = '{ev(0,0,0,0,0,0,0,0, 32'h3004, 16'h0003, 0, 0), 32'h3000, 0, 0};
      tbl[2]  = '{ev(0,1,1,1,0,0,0,1, 32'h3004, 16'h0003, 0, 0), 32'h3014, 0, 0};
      tbl[3]  = '{ev(0,1,1,1,1,0,0,0, 32'h3010, 16'h0003, 0, 0), 32'h3004, 1, 0};
      tbl[4]  = '{ev(0,1,1,0,0,1,0,0, 32'h3020, 0, 26'h0000C10, 0), 32'h3040, 0, 0};
      tbl[5]  = '{ev(0,1,1,0,0,0,1,0, 32'h3020, 0, 0, 32'h3100), 32'h3100, 0, 0};
      tbl[6]  = '{ev(0,1,1,1,0,0,0,1, 32'h3000, 16'hFFFE, 0, 0), 32'h2FFC, 0, 0};
      tbl[7]  = '{ev(0,1,1,1,0,1,1,1, 32'h3000, 16'h0010, 26'h1, 32'h1234_5678), 32'h1234_5678, 0, 0};
      tbl[8]  = '{ev(0,1,1,1,0,1,0,1, 32'hF000_0000, 16'h0010, 26'h3FF_FFFF, 0), 32'hFFFF_FFFC, 0, 0};
      tbl[9]  = '{ev(1,1,1,0,0,0,1,0, 32'h3020, 0, 0, 32'h3100), 32'h3000, 0, 0};
      tbl[10] = '{ev(0,0,1,0,0,0,1,0, 32'h3020, 0, 0, 32'h3100), 32'h3000, 0, 1};
      tbl[11] = '{ev(0,1,0,1,0,0,0,1, 32'h3004, 16'h0003, 0, 0), 32'h3004, 0, 0};
      tbl[12] = '{ev(0,1,1,1,0,0,0,0, 32'h3004, 16'h0003, 0, 0), 32'h3004, 0, 0};
      tbl[13] = '{ev(0,1,1,1,0,0,0,1, 32'hFFFF_FFF8, 16'h0001, 0, 0), 32'h0000_0000, 0, 0};
      tbl[14] = '{ev(0,1,1,1,1,0,0,1, 32'h3000, 16'h0010, 0, 0), 32'h3044, 0, 0};
      do_reset();
      drive(idle);
      chk("reset_pcf", pc_f, 32'h3000);
      chk("reset_pend", redirect_pending, 0);
      chk("reset_null", nullify_fd, 0);
      for (int k = 0; k < 15; k++) begin
         do_reset();
         drive(tbl[k].i);
         chk($sformatf("v%0d_npc", k), npc, tbl[k].e_npc);
         chk($sformatf("v%0d_null", k), nullify_fd, tbl[k].e_null);
         chk($sformatf("v%0d_link", k), link_pc, tbl[k].i.dpc + 32'd8);
         @(posedge clk);
         drive(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         chk($sformatf("v%0d_pcf", k), pc_f, tbl[k].e_npc);
         chk($sformatf("v%0d_pend", k), redirect_pending, tbl[k].e_pend);
      end
      // sequential fetch, then jal parked across two not-ready cycles
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive(idle);
         chk("seq_pcf", pc_f, 32'h3000 + 32'(4 * k));
         @(posedge clk);
      end
      r = ev(0, 0, 1, 0, 0, 1, 0, 0, 32'h3020, 0, 26'h0000C10, 0);
      drive(r);
      chk("jal_pcf", pc_f, 32'h3024);
      chk("jal_npc_hold", npc, 32'h3024);
      @(posedge clk);
      drive(r);
      chk("jal_wait1", redirect_pending, 1);
      chk("jal_hold1", pc_f, 32'h3024);
      @(posedge clk);
      r.rdy = 1;
      drive(r);
      chk("jal_wait2", redirect_pending, 1);
      chk("jal_npc", npc, 32'h3040);
      @(posedge clk);
      r = ev(1, 1, 1, 0, 0, 0, 1, 0, 32'h3040, 0, 0, 32'h3100);
      drive(r);
      chk("jal_pcf_after", pc_f, 32'h3040);
      chk("jal_seq", redirect_pending, 0);
      // jr held by stall, then released
      @(posedge clk);
      drive(r);
      chk("jr_stall_pcf", pc_f, 32'h3040);
      chk("jr_stall_pend", redirect_pending, 0);
      @(posedge clk);
      r.stl = 0;
      drive(r);
      chk("jr_npc", npc, 32'h3100);
      @(posedge clk);
      // stall overrides ready while parked; reset discards the parked redirect
      drive(ev(0, 0, 1, 0, 0, 0, 1, 0, 32'h3100, 0, 0, 32'h5000));
      chk("jr_pcf", pc_f, 32'h3100);
      @(posedge clk);
      drive(ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("wait_stall_npc", npc, 32'h3100);
      @(posedge clk);
      drive(idle);
      chk("wait_stall_pend", redirect_pending, 1);
      reset = 1; imem_ready = 0;
      @(posedge clk);
      drive(idle);
      chk("wrst_pcf", pc_f, 32'h3000);
      chk("wrst_pend", redirect_pending, 0);
      @(posedge clk);
      drive(idle);
      chk("wrst_no_stale", pc_f, 32'h3004);
      // randomized run against the model
      do_reset();
      m_pc = 32'h3000;
      pq.delete();
      for (int k = 0; k < 600; k++) begin
         r = ev($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                1'($urandom), $urandom, 16'($urandom), 26'($urandom), $urandom);
         r.rst = $urandom_range(0, 49) == 0;
         drive(r);
         model_step(r);
         @(posedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Fetch-side consumer of the D-stage branch compare result (`to_branch`) in the 5-stage MIPS pipeline.
- Owns the F-stage PC register and computes the redirect target for branches, j/jal and jr/jalr.
- Honours MIPS delay-slot semantics, and nullifies the delay slot of a not-taken branch-likely.
- Tolerates an instruction memory that is not ready every cycle by holding a pending redirect until the delay slot has been captured.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset.
- PC_STEP, 4: sequential increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes the PC and the F/D register.
- imem_ready  input  1  the instruction at pc_f is available this cycle; F/D captures when imem_ready && !stall.
- d_valid  input  1  the D-stage instruction is real (not a bubble).
- d_is_branch  input  1  D is a conditional branch (beq/bne/bgez/...).
- d_is_likely  input  1  D is the branch-likely variant; qualifies d_is_branch.
- d_is_jump  input  1  D is j/jal.
- d_is_jr  input  1  D is jr/jalr.
- to_branch  input  1  compare result for the D-stage branch.
- d_pc  input  32  PC of the D-stage instruction.
- d_imm16  input  16  branch offset field.
- d_index26  input  26  jump index field.
- d_rs_value  input  32  forwarded rs value for jr/jalr.
- pc_f  output  32  current fetch PC; registered.
- npc  output  32  value pc_f takes on the next advancing edge; combinational.
- nullify_fd  output  1  F/D must load a bubble instead of the fetched instruction this cycle.
- link_pc  output  32  d_pc + 8, for jal/jalr/bgezal writeback.
- redirect_pending  output  1  high while in state WAIT_DS.

Behaviour:
- Reset (synchronous): pc_f=RESET_PC, state=SEQ, pending target=0, pend_redir=0, pend_null=0. Hence nullify_fd=0 and redirect_pending=0.
- adv = imem_ready && !stall.
- accept = d_valid && !stall. A control-transfer event is sampled only on accept; a stalled D instruction is re-evaluated next cycle.
- Taken condition: take = d_is_jr || d_is_jump || (d_is_branch && to_branch).
- Nullify condition: kill = d_is_branch && d_is_likely && !to_branch.
- Target priority is jr > jump > branch:
  - jr: d_rs_value.
  - jump: {(d_pc+4)[31:28], d_index26, 2'b00}.
  - branch: d_pc + 4 + (sign_extend(d_imm16) << 2), 32-bit wrap-around with no overflow detection.
- Multiple type flags asserted together resolve by priority; no error is raised.
- State SEQ:
  - accept && (take || kill) && adv: the delay slot is captured this edge. pc_f <= target if take, else pc_f+4. nullify_fd=kill (combinational, same cycle). Stay in SEQ.
  - accept && (take || kill) && !adv: latch the target, pend_redir=take, pend_null=kill. pc_f holds; go to WAIT_DS.
  - Otherwise: if adv, pc_f <= pc_f + PC_STEP; else hold.
- State WAIT_DS:
  - New D events are ignored; D holds the delay slot bubble.
  - On adv: pc_f <= (pend_redir ? pending target : pc_f+4). nullify_fd=pend_null. Clear both flags; go to SEQ.
  - stall overrides imem_ready: remain in WAIT_DS.
- npc always reflects the selection above for the current cycle. It equals pc_f whenever !adv.
- pc_f wraps at 32'hFFFF_FFFC → 0. No alignment check.
- Reset asserted in any state, including WAIT_DS, discards the pending redirect in that cycle.
- A redirect accepted in the same cycle as reset is lost.

Test Plan:
- Reset, then imem_ready=1 for 3 cycles with no events → pc_f sequence 3000, 3004, 3008, 300C.
- beq at d_pc=3004, imm16=16'h0003, to_branch=1, adv=1 → npc=3014; pc_f=3014 next edge; nullify_fd=0; link_pc=300C.
- beql at d_pc=3010, to_branch=0, adv=1 → nullify_fd=1 that cycle; pc_f 3014→3018.
- jal at d_pc=3020, index26=26'h0000C10, imem_ready=0 for 2 cycles → redirect_pending=1 and pc_f holds 3024. First imem_ready=1 → pc_f=00003040, state SEQ.
- jr with d_rs_value=3100 and stall=1 for 2 cycles → pc_f and state unchanged. When stall drops with adv=1 → pc_f=3100.
- Reset during WAIT_DS → pc_f=3000 and redirect_pending=0 next cycle; the stale target is never loaded.
